// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame controller and its helpers.
// Holds the geometry limits, counter width, the mode encodings used by the
// output mux and the frame-controller state type.
package sobel_pkg;

  localparam int MAX_LINE_WIDTH = 2100;
  localparam int MAX_LINES      = 2047;
  localparam int CNT_W          = 12;
  localparam int MIN_DIM        = 3;

  typedef enum logic [1:0] {
    MODE_BYPASS     = 2'b00,
    MODE_EDGE       = 2'b01,
    MODE_EDGE_BLACK = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    LOCKED  = 2'b10
  } state_t;

  // The reserved encoding 11 falls back to bypass.
  function automatic mode_t sanitize_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_EDGE;
      2'b10:   return MODE_EDGE_BLACK;
      default: return MODE_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Video timing and status bundle for sobel_frame_ctrl.
// master: timing source (drives hsync/vsync/de/mode_req, observes status).
// slave : frame controller (observes timing, drives mode_out/locked/geometry/counters).
interface sobel_frame_ctrl_if;
  import sobel_pkg::*;

  logic             hsync;
  logic             vsync;
  logic             de;
  logic [1:0]       mode_req;
  logic [1:0]       mode_out;
  logic             locked;
  logic [CNT_W-1:0] line_width;
  logic [CNT_W-1:0] frame_lines;
  logic             width_err;
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;

  modport master (
    output hsync, vsync, de, mode_req,
    input  mode_out, locked, line_width, frame_lines, width_err, x_cnt, y_cnt
  );

  modport slave (
    input  hsync, vsync, de, mode_req,
    output mode_out, locked, line_width, frame_lines, width_err, x_cnt, y_cnt
  );

endinterface

// File: rtl/timing_edge_det.sv
// Registers vsync and de and flags the vsync rising edge and the de falling
// edge in the cycle the new level is sampled.
// Ports: clk, rst (sync, active-low), vsync, de in; vs_rise, de_fall out.
module timing_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic de,
  output logic vs_rise,
  output logic de_fall
);

  logic vsync_d, vsync_q;
  logic de_d, de_q;

  always_comb begin
    vsync_d = vsync;
    de_d    = de;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      de_q    <= de_d;
    end
  end

  assign vs_rise = vsync & ~vsync_q;
  assign de_fall = ~de & de_q;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller for the Sobel pipeline: measures line width and
// frame height from de/vsync, locks onto a stable geometry and applies the
// requested mode only at frame boundaries while locked.
// Ports: clk, rst (sync, active-low), bus (slave side of sobel_frame_ctrl_if).
//
// state   | meaning
// IDLE    | after reset, waiting for the first frame boundary
// MEASURE | measuring geometry, waiting for one good frame
// LOCKED  | geometry stable, edge modes applied
module sobel_frame_ctrl
  import sobel_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  sobel_frame_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(MAX_LINE_WIDTH);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(MAX_LINES);
  localparam logic [CNT_W-1:0] D_MIN = CNT_W'(MIN_DIM);

  logic vs_rise, de_fall;

  timing_edge_det u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .vsync   (bus.vsync),
    .de      (bus.de),
    .vs_rise (vs_rise),
    .de_fall (de_fall)
  );

  state_t           state_d, state_q;
  mode_t            mode_d, mode_q;
  logic [CNT_W-1:0] x_cnt_d, x_cnt_q;
  logic [CNT_W-1:0] y_cnt_d, y_cnt_q;
  logic [CNT_W-1:0] line_width_d, line_width_q;
  logic [CNT_W-1:0] frame_lines_d, frame_lines_q;
  logic [CNT_W-1:0] ref_w_d, ref_w_q;
  logic [CNT_W-1:0] ref_h_d, ref_h_q;
  logic             width_err_d, width_err_q;

  // Geometry of the closing frame, including a line that ends in the same
  // cycle as the vsync rise.
  logic [CNT_W-1:0] y_inc, y_eff, w_eff;
  logic             frame_good, geom_match;

  assign y_inc      = (y_cnt_q == Y_MAX) ? y_cnt_q : y_cnt_q + 1'b1;
  assign y_eff      = de_fall ? y_inc : y_cnt_q;
  assign w_eff      = de_fall ? x_cnt_q : line_width_q;
  assign frame_good = !width_err_q && (w_eff >= D_MIN) && (y_eff >= D_MIN);
  assign geom_match = (w_eff == ref_w_q) && (y_eff == ref_h_q);

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    line_width_d  = line_width_q;
    frame_lines_d = frame_lines_q;
    ref_w_d       = ref_w_q;
    ref_h_d       = ref_h_q;
    width_err_d   = width_err_q;

    if (bus.de) begin
      if (x_cnt_q == X_MAX) width_err_d = 1'b1;
      else                  x_cnt_d     = x_cnt_q + 1'b1;
    end

    if (de_fall) begin
      line_width_d = x_cnt_q;
      x_cnt_d      = '0;
      y_cnt_d      = y_inc;
    end

    if (vs_rise) begin
      frame_lines_d = y_eff;
      // A de cycle on the vsync rise is pixel 0 of the new frame.
      x_cnt_d       = bus.de ? CNT_W'(1) : '0;
      y_cnt_d       = '0;
      width_err_d   = 1'b0;

      case (state_q)
        IDLE:    state_d = MEASURE;
        MEASURE: begin
          if (frame_good) begin
            state_d = LOCKED;
            ref_w_d = w_eff;
            ref_h_d = y_eff;
          end
        end
        LOCKED:  if (!(frame_good && geom_match)) state_d = MEASURE;
        default: state_d = IDLE;
      endcase

      mode_d = (state_d == LOCKED) ? sanitize_mode(bus.mode_req) : MODE_BYPASS;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      mode_q        <= MODE_BYPASS;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      line_width_q  <= '0;
      frame_lines_q <= '0;
      ref_w_q       <= '0;
      ref_h_q       <= '0;
      width_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_width_q  <= line_width_d;
      frame_lines_q <= frame_lines_d;
      ref_w_q       <= ref_w_d;
      ref_h_q       <= ref_h_d;
      width_err_q   <= width_err_d;
    end
  end

  assign bus.mode_out    = mode_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.line_width  = line_width_q;
  assign bus.frame_lines = frame_lines_q;
  assign bus.width_err   = width_err_q;
  assign bus.x_cnt       = x_cnt_q;
  assign bus.y_cnt       = y_cnt_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl. Stimulus pushes expected values
// tagged with the clock edge after which they must hold; a monitor on the
// falling edge pops and compares them.
module tb_sobel_frame_ctrl;

  localparam int S_MODE = 0;
  localparam int S_LOCK = 1;
  localparam int S_LW   = 2;
  localparam int S_FL   = 3;
  localparam int S_WERR = 4;
  localparam int S_X    = 5;
  localparam int S_Y    = 6;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  logic clk;
  logic rst;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t sb[$];
  exp_t e;

  sobel_frame_ctrl_if bus ();

  sobel_frame_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int actual(input int s);
    case (s)
      S_MODE:  return int'(bus.mode_out);
      S_LOCK:  return int'(bus.locked);
      S_LW:    return int'(bus.line_width);
      S_FL:    return int'(bus.frame_lines);
      S_WERR:  return int'(bus.width_err);
      S_X:     return int'(bus.x_cnt);
      default: return int'(bus.y_cnt);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_MODE:  return "mode_out";
      S_LOCK:  return "locked";
      S_LW:    return "line_width";
      S_FL:    return "frame_lines";
      S_WERR:  return "width_err";
      S_X:     return "x_cnt";
      default: return "y_cnt";
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e = sb.pop_front();
      checks++;
      if (actual(e.sig) !== e.val) begin
        errors++;
        $display("FAIL %s @edge %0d: got %0d, expected %0d",
                 sig_name(e.sig), edge_cnt, actual(e.sig), e.val);
      end
    end
  end

  task automatic push(input int s, input int v);
    sb.push_back('{cyc: edge_cnt, sig: s, val: v});
  endtask

  task automatic tick(input logic v, input logic d);
    bus.vsync = v;
    bus.de    = d;
    bus.hsync = ~d & ~v;
    @(posedge clk);
    #1;
  endtask

  task automatic push_reset_vals();
    push(S_MODE, 0); push(S_LOCK, 0); push(S_LW, 0); push(S_FL, 0);
    push(S_WERR, 0); push(S_X, 0); push(S_Y, 0);
  endtask

  // One line of w de cycles, optionally followed by three blanking cycles.
  task automatic line(input int w, input bit blank);
    for (int k = 1; k <= w; k++) begin
      tick(1'b0, 1'b1);
      if (k == w) push(S_X, (w > 2100) ? 2100 : w);
    end
    if (blank) begin
      repeat (3) tick(1'b0, 1'b0);
      push(S_LW, (w > 2100) ? 2100 : w);
    end
  endtask

  // n lines of 16 pixels; the last line may end directly on the vsync rise.
  task automatic frame(input int n, input bit coincide_last);
    for (int i = 0; i < n; i++) begin
      if (coincide_last && i == n - 1) begin
        line(16, 1'b0);
      end else begin
        line(16, 1'b1);
        push(S_Y, i + 1);
      end
    end
  endtask

  // vsync pulse; status checked once the pulse is over.
  task automatic vs_pulse(input int lk, input int md, input int fl);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    push(S_LOCK, lk); push(S_MODE, md); push(S_FL, fl);
    push(S_WERR, 0); push(S_X, 0); push(S_Y, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b0;
    bus.vsync    = 1'b0;
    bus.de       = 1'b0;
    bus.hsync    = 1'b0;
    bus.mode_req = 2'b01;
    repeat (3) tick(1'b0, 1'b0);
    push_reset_vals();
    rst = 1'b1;
    tick(1'b0, 1'b0);

    // Acquire lock on 16x8 frames
    vs_pulse(0, 0, 0);
    frame(8, 1'b0);
    vs_pulse(1, 1, 8);
    frame(8, 1'b0);
    vs_pulse(1, 1, 8);

    // Mode request changed mid-frame applies only at the next boundary
    for (int i = 0; i < 8; i++) begin
      line(16, 1'b1);
      if (i == 3) bus.mode_req = 2'b10;
      if (i == 4) push(S_MODE, 1);
    end
    vs_pulse(1, 2, 8);

    // Short frame drops lock, next good frame relocks
    frame(7, 1'b0);
    vs_pulse(0, 0, 7);
    frame(8, 1'b0);
    vs_pulse(1, 2, 8);

    // Oversized line
    frame(2, 1'b0);
    for (int k = 1; k <= 2105; k++) begin
      tick(1'b0, 1'b1);
      if (k == 2100) begin push(S_X, 2100); push(S_WERR, 0); end
      if (k == 2101) begin push(S_X, 2100); push(S_WERR, 1); end
      if (k == 2105) begin push(S_X, 2100); push(S_WERR, 1); end
    end
    repeat (3) tick(1'b0, 1'b0);
    push(S_LW, 2100); push(S_WERR, 1); push(S_Y, 3);
    for (int i = 0; i < 5; i++) line(16, 1'b1);
    push(S_WERR, 1);
    vs_pulse(0, 0, 8);
    frame(8, 1'b0);
    vs_pulse(1, 2, 8);

    // Last line ends on the vsync rise; reserved mode request -> bypass
    frame(8, 1'b1);
    bus.mode_req = 2'b11;
    vs_pulse(1, 0, 8);
    bus.mode_req = 2'b01;

    // Reset mid-frame while locked
    frame(3, 1'b0);
    rst = 1'b0;
    tick(1'b0, 1'b1);
    push_reset_vals();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    frame(5, 1'b0);
    vs_pulse(0, 0, 5);
    frame(8, 1'b0);
    vs_pulse(1, 1, 8);
    line(16, 1'b1);

    repeat (4) tick(1'b0, 1'b0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
